wb_trace_buffer: RTL



---
 rtl/wb_trace_buffer_pkg.sv | 30 +++
 rtl/wb_trace_buffer_if.sv | 27 ++
 rtl/wb_trace_buffer_sync_fifo.sv | 82 ++++++++
 rtl/wb_trace_buffer.sv | 92 +++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared trace record layout for the WB trace buffer and the trace comparator.
// A record is {pc, wnum, wdata}, with wdata in the least significant bits.
package wb_trace_buffer_pkg;

  localparam int unsigned PcW       = 32;
  localparam int unsigned WnumW     = 5;
  localparam int unsigned WdataW    = 32;
  localparam int unsigned TraceRecW = PcW + WnumW + WdataW;

  localparam int unsigned WdataLsb = 0;
  localparam int unsigned WnumLsb  = WdataLsb + WdataW;
  localparam int unsigned PcLsb    = WnumLsb + WnumW;

  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [WnumW-1:0]  wnum;
    logic [WdataW-1:0] wdata;
  } trace_rec_t;

  function automatic trace_rec_t pack_rec(input logic [PcW-1:0]    pc,
                                          input logic [WnumW-1:0]  wnum,
                                          input logic [WdataW-1:0] wdata);
    trace_rec_t rec;
    rec.pc    = pc;
    rec.wnum  = wnum;
    rec.wdata = wdata;
    return rec;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Valid/ready trace stream from the WB trace buffer to a trace consumer.
interface wb_trace_buffer_if;
  import wb_trace_buffer_pkg::*;

  logic              trace_valid;
  logic              trace_ready;
  logic [PcW-1:0]    trace_pc;
  logic [WnumW-1:0]  trace_wnum;
  logic [WdataW-1:0] trace_wdata;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_wnum,
    output trace_wdata,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_wnum,
    input  trace_wdata,
    output trace_ready
  );

endinterface

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Synchronous FIFO with an occupancy counter and a registered head output.
// The head register is zero whenever the FIFO is empty.
module wb_trace_buffer_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       din_i,
  output logic [Width-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(Depth);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam ptr_t PtrOne  = ptr_t'(1);

  logic [Width-1:0] mem_q [Depth];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  cnt_t             remain;
  logic [Width-1:0] head_q, head_d;
  logic             pop_ok, push_ok;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = head_q;

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
    remain   = pop_ok ? count_q - CntOne : count_q;

    count_d = remain;
    if (push_ok) begin
      count_d = remain + CntOne;
    end

    // Next head: oldest surviving entry, else the incoming word, else zero.
    head_d = '0;
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_ok) begin
      head_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired register-file writes from WB into a FIFO and streams them to a trace
// consumer; keeps a wrapping commit counter, a saturating drop counter and a sticky overflow.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = 32,
  parameter int unsigned DropW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en_i,
  input  logic [PcW-1:0]         pc_wb_i,
  input  logic                   reg_we_wb_i,
  input  logic [WnumW-1:0]       rw_wb_i,
  input  logic [WdataW-1:0]      reg_din_wb_i,
  input  logic                   stall_memwb_i,
  input  logic                   is_exception_i,
  wb_trace_buffer_if.master      trace_io,
  output logic [CntW-1:0]        commit_cnt_o,
  output logic [DropW-1:0]       drop_cnt_o,
  output logic                   overflow_o,
  output logic [$clog2(Depth):0] occupancy_o
);

  localparam logic [CntW-1:0]  CommitOne = CntW'(1);
  localparam logic [DropW-1:0] DropOne   = DropW'(1);

  logic       capture, push, pop, drop;
  logic       full, empty;
  trace_rec_t wr_rec, rd_rec;

  logic [CntW-1:0]  commit_q, commit_d;
  logic [DropW-1:0] drop_q, drop_d;
  logic             overflow_q, overflow_d;

  assign capture = trace_en_i & reg_we_wb_i & (rw_wb_i != '0) & ~stall_memwb_i & ~is_exception_i;
  assign pop     = ~empty & trace_io.trace_ready;
  assign push    = capture & (~full | pop);
  // A full FIFO with no pop discards the newest record.
  assign drop    = capture & full & ~pop;
  assign wr_rec  = pack_rec(pc_wb_i, rw_wb_i, reg_din_wb_i);

  wb_trace_buffer_sync_fifo #(
    .Width (TraceRecW),
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (wr_rec),
    .dout_o  (rd_rec),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy_o)
  );

  assign trace_io.trace_valid = ~empty;
  assign trace_io.trace_pc    = rd_rec.pc;
  assign trace_io.trace_wnum  = rd_rec.wnum;
  assign trace_io.trace_wdata = rd_rec.wdata;

  always_comb begin
    commit_d   = commit_q;
    drop_d     = drop_q;
    overflow_d = overflow_q | drop;
    if (push) begin
      commit_d = commit_q + CommitOne;
    end
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DropOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q   <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      commit_q   <= commit_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign commit_cnt_o = commit_q;
  assign drop_cnt_o   = drop_q;
  assign overflow_o   = overflow_q;

endmodule
